// File: rtl/stopwatch_mmss.sv
// MM:SS stopwatch driven by the clock divider's slow tick; synchronises tick_in,
// counts its rising edges as BCD digits under start/stop/clear control.
module stopwatch_mmss #(
   parameter int SYNC_STAGES = 2,
   parameter bit STOP_AT_MAX = 1'b0
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       tick_in,
   input  logic       start_stop,
   input  logic       clear,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       running,
   output logic       done,
   output logic       wrap_pulse
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                 state_q, state_n;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   tick_prev_q;
   logic                   tick_rise;
   logic [3:0]             so_q, st_q, mo_q, mt_q;
   logic [3:0]             so_n, st_n, mo_n, mt_n;
   logic                   wrap_n;
   logic                   at_max;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         sync_q      <= '0;
         tick_prev_q <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], tick_in};
         tick_prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign tick_rise = sync_q[SYNC_STAGES-1] & ~tick_prev_q;
   assign at_max    = (mt_q == 4'd5) && (mo_q == 4'd9) && (st_q == 4'd5) && (so_q == 4'd9);

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_n = state_q;
      so_n    = so_q;
      st_n    = st_q;
      mo_n    = mo_q;
      mt_n    = mt_q;
      wrap_n  = 1'b0;

      if (clear) begin
         state_n = ST_IDLE;
         so_n    = 4'd0;
         st_n    = 4'd0;
         mo_n    = 4'd0;
         mt_n    = 4'd0;
      end else begin
         case (state_q)
            ST_IDLE, ST_PAUSE: begin
               // A tick arriving with the start pulse is dropped: counting begins next tick.
               if (start_stop) state_n = ST_RUN;
            end
            ST_RUN: begin
               if (start_stop) state_n = ST_PAUSE;
               if (tick_rise) begin
                  if (at_max) begin
                     if (STOP_AT_MAX) begin
                        state_n = ST_DONE;
                     end else begin
                        so_n   = 4'd0;
                        st_n   = 4'd0;
                        mo_n   = 4'd0;
                        mt_n   = 4'd0;
                        wrap_n = 1'b1;
                     end
                  end else if (so_q != 4'd9) begin
                     so_n = so_q + 4'd1;
                  end else begin
                     so_n = 4'd0;
                     if (st_q != 4'd5) begin
                        st_n = st_q + 4'd1;
                     end else begin
                        st_n = 4'd0;
                        if (mo_q != 4'd9) begin
                           mo_n = mo_q + 4'd1;
                        end else begin
                           mo_n = 4'd0;
                           mt_n = mt_q + 4'd1;
                        end
                     end
                  end
               end
            end
            ST_DONE: ;
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         so_q       <= 4'd0;
         st_q       <= 4'd0;
         mo_q       <= 4'd0;
         mt_q       <= 4'd0;
         wrap_pulse <= 1'b0;
      end else begin
         state_q    <= state_n;
         so_q       <= so_n;
         st_q       <= st_n;
         mo_q       <= mo_n;
         mt_q       <= mt_n;
         wrap_pulse <= wrap_n;
      end
   end

   assign sec_ones = so_q;
   assign sec_tens = st_q;
   assign min_ones = mo_q;
   assign min_tens = mt_q;
   assign running  = (state_q == ST_RUN);
   assign done     = (state_q == ST_DONE);

endmodule
